// File: rtl/seq_run_detector_if.sv
// Bundled control inputs and status outputs of seq_run_detector.
// hit_cnt is present only when SEQ_RUN_HITCNT_EN is defined.
interface seq_run_detector_if #(
  parameter int CNT_W = 4,
  parameter int HIT_W = 8
);
  logic             en;
  logic             clr;
  logic             w;
  logic [1:0]       mode;
  logic             z;
  logic             z_val;
  logic [CNT_W-1:0] run_len;
  logic [1:0]       curr_state;
`ifdef SEQ_RUN_HITCNT_EN
  logic [HIT_W-1:0] hit_cnt;

  modport master (output en, clr, w, mode,
                  input  z, z_val, run_len, curr_state, hit_cnt);
  modport slave  (input  en, clr, w, mode,
                  output z, z_val, run_len, curr_state, hit_cnt);
`else
  modport master (output en, clr, w, mode,
                  input  z, z_val, run_len, curr_state);
  modport slave  (input  en, clr, w, mode,
                  output z, z_val, run_len, curr_state);
`endif
endinterface

// File: rtl/seq_run_detector.sv
// Serial run detector: flags RUN_LEN identical consecutive accepted symbols.
// Optional rising-edge hit counter enabled by macro SEQ_RUN_HITCNT_EN.
module seq_run_detector #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 4,
  parameter int HIT_W   = 8
) (
  input logic                Clock,
  input logic                nReset,
  seq_run_detector_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN0 = 2'd1,
    RUN1 = 2'd2,
    BAD  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_RUN = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_z;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (bus.clr) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.en) begin
            w_state_nxt = bus.w ? RUN1 : RUN0;
            w_cnt_nxt   = LP_ONE;
          end
        end
        RUN0, RUN1: begin
          if (bus.en) begin
            if (bus.w == (r_state == RUN1)) begin
              if (r_cnt != LP_RUN) w_cnt_nxt = r_cnt + LP_ONE;
            end else begin
              // A new symbol starts its own run immediately, no IDLE gap.
              w_state_nxt = bus.w ? RUN1 : RUN0;
              w_cnt_nxt   = LP_ONE;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // mode[1] masks runs of ones, mode[0] masks runs of zeros.
  assign w_z = (r_cnt == LP_RUN) &&
               (((r_state == RUN1) && !bus.mode[1]) ||
                ((r_state == RUN0) && !bus.mode[0]));

  assign bus.z          = w_z;
  assign bus.z_val      = (r_state == RUN1);
  assign bus.run_len    = r_cnt;
  assign bus.curr_state = r_state;

`ifdef SEQ_RUN_HITCNT_EN
  logic             r_z_q;
  logic [HIT_W-1:0] r_hit;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_z_q <= 1'b0;
      r_hit <= '0;
    end else begin
      r_z_q <= w_z;
      if (bus.clr)
        r_hit <= '0;
      else if (w_z && !r_z_q && (r_hit != {HIT_W{1'b1}}))
        r_hit <= r_hit + HIT_W'(1);
    end
  end

  assign bus.hit_cnt = r_hit;
`endif

endmodule

// File: tb/tb_seq_run_detector.sv
// Randomized and directed bench for seq_run_detector against a run-length model.
module tb_seq_run_detector;
  localparam int RUN_LEN = 4;
  localparam int CNT_W   = 4;
  localparam int HIT_W   = 2;
  localparam int HIT_MAX = (1 << HIT_W) - 1;

  logic Clock = 1'b0;
  logic nReset;
  always #5 Clock = ~Clock;

  seq_run_detector_if #(.CNT_W(CNT_W), .HIT_W(HIT_W)) bus();

  seq_run_detector #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W), .HIT_W(HIT_W)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: length of the current run (0 = no symbol yet) and its symbol.
  int m_len;
  bit m_val;
  bit m_zq;
  int m_hit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_z(input logic [1:0] mode);
    if (m_len != RUN_LEN) return 1'b0;
    case (mode)
      2'b00:   return 1'b1;
      2'b01:   return m_val;
      2'b10:   return !m_val;
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_reset();
    m_len = 0; m_val = 0; m_zq = 0; m_hit = 0;
  endtask

  task automatic check_all();
    chk("z",          {31'd0, bus.z},          {31'd0, m_z(bus.mode)});
    chk("z_val",      {31'd0, bus.z_val},      {31'd0, (m_len != 0) && m_val});
    chk("run_len",    32'(bus.run_len),        32'(m_len));
    chk("curr_state", 32'(bus.curr_state),     (m_len == 0) ? 32'd0 : (m_val ? 32'd2 : 32'd1));
`ifdef SEQ_RUN_HITCNT_EN
    chk("hit_cnt",    32'(bus.hit_cnt),        32'(m_hit));
`endif
  endtask

  task automatic apply(input bit en, input bit clr, input bit w);
    bit zb;
    bus.en = en; bus.clr = clr; bus.w = w;
    @(posedge Clock);
    zb = m_z(bus.mode);
    if (clr) m_hit = 0;
    else if (zb && !m_zq && m_hit < HIT_MAX) m_hit++;
    m_zq = zb;
    if (clr) begin
      m_len = 0; m_val = 0;
    end else if (en) begin
      if (m_len == 0 || w != m_val) begin
        m_val = w; m_len = 1;
      end else if (m_len < RUN_LEN) begin
        m_len++;
      end
    end
    #1;
    check_all();
  endtask

  task automatic async_reset();
    @(negedge Clock);
    #2 nReset = 1'b0;
    m_reset();
    #1 check_all();
    chk("rst_run_len", 32'(bus.run_len), 32'd0);
    @(posedge Clock);
    #3 nReset = 1'b1;
    #1 check_all();
  endtask

  initial begin
    bit w_r;
    nReset = 1'b0;
    bus.en = 0; bus.clr = 0; bus.w = 0; bus.mode = 2'b00;
    m_reset();
    #12;
    check_all();
    #5 nReset = 1'b1;
    // Release is not a sample.
    apply(0, 0, 1);
    chk("release_no_sample", 32'(bus.run_len), 32'd0);

    // Run of five zeros, both-values mode.
    for (int i = 0; i < 5; i++) begin
      apply(1, 0, 0);
      chk("zeros_z", {31'd0, bus.z}, (i >= 3) ? 32'd1 : 32'd0);
    end
    chk("zeros_sat", 32'(bus.run_len), 32'd4);

    // Zeros-only mode suppresses a run of ones until mode changes.
    apply(1, 1, 0);
    bus.mode = 2'b10;
    for (int i = 0; i < 4; i++) apply(1, 0, 1);
    chk("mode10_z", {31'd0, bus.z}, 32'd0);
    chk("mode10_zval", {31'd0, bus.z_val}, 32'd1);
    bus.mode = 2'b00;
    #1;
    chk("mode_switch_z", {31'd0, bus.z}, 32'd1);
    check_all();

    // Broken run restarts the count.
    apply(1, 1, 0);
    begin
      bit     seq [8]  = '{1, 1, 1, 0, 1, 1, 1, 1};
      int     lens [8] = '{1, 2, 3, 1, 1, 2, 3, 4};
      for (int i = 0; i < 8; i++) begin
        apply(1, 0, seq[i]);
        chk("break_len", 32'(bus.run_len), 32'(lens[i]));
      end
      chk("break_z", {31'd0, bus.z}, 32'd1);
    end

    // Enable gaps hold the count.
    apply(1, 1, 0);
    apply(1, 0, 0);
    apply(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 1);
      chk("hold_len", 32'(bus.run_len), 32'd2);
    end
    apply(1, 0, 0);
    apply(1, 0, 0);
    chk("hold_z", {31'd0, bus.z}, 32'd1);

    // Synchronous clear and asynchronous reset mid-run.
    apply(1, 1, 0);
    for (int i = 0; i < 3; i++) apply(1, 0, 1);
    apply(1, 1, 1);
    chk("clr_len", 32'(bus.run_len), 32'd0);
    apply(1, 0, 1);
    chk("clr_restart", 32'(bus.run_len), 32'd1);
    apply(1, 0, 1);
    apply(1, 0, 1);
    async_reset();
    apply(1, 0, 1);
    chk("rst_restart", 32'(bus.run_len), 32'd1);

`ifdef SEQ_RUN_HITCNT_EN
    // Five separate runs saturate a 2-bit counter.
    apply(0, 1, 0);
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < 4; i++) apply(1, 0, r[0]);
    apply(0, 0, 0);
    apply(0, 0, 0);
    chk("hit_sat", 32'(bus.hit_cnt), 32'd3);
    apply(0, 1, 0);
    chk("hit_clr", 32'(bus.hit_cnt), 32'd0);
`endif

    // Randomized traffic with biased runs.
    w_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        bus.mode = 2'($urandom_range(0, 3));
        #1 check_all();
      end
      if ($urandom_range(0, 3) == 0) w_r = ~w_r;
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, w_r);
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seq_run_detector.md
SEQ_RUN_DETECTOR -- requirements
Module: seq_run_detector

Interface
REQ-001 The block SHALL have parameter RUN_LEN, default 4: run length that asserts z; legal range 2..(2**CNT_W)-1.
REQ-002 The block SHALL have parameter CNT_W, default 4: width of run_len.
REQ-003 The block SHALL have parameter HIT_W, default 8: width of hit_cnt.
REQ-004 Port Clock, input, 1 bit: single clock; all state updates on its posedge.
REQ-005 Port nReset, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port en, input, 1 bit: sample enable; w is consumed only when en=1.
REQ-007 Port clr, input, 1 bit: synchronous clear of run tracking.
REQ-008 Port w, input, 1 bit: serial data symbol.
REQ-009 Port mode, input, 2 bits: 00 detect runs of both values, 01 ones only, 10 zeros only, 11 detection disabled.
REQ-010 Port z, output, 1 bit: run of RUN_LEN identical symbols present.
REQ-011 Port z_val, output, 1 bit: symbol value of the current run.
REQ-012 Port run_len, output, CNT_W bits: current run length, saturating at RUN_LEN.
REQ-013 Port curr_state, output, 2 bits: diagnostic state code (IDLE=0, RUN0=1, RUN1=2).
REQ-014 Port hit_cnt, output, HIT_W bits: detection count; present only per REQ-030.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE (no symbol yet), RUN0 (tracking zeros), RUN1 (tracking ones); code 3 is unreachable and SHALL recover to IDLE on the next edge.
REQ-016 In IDLE with en=1, the FSM SHALL go to RUN<w> and set the count to 1.
REQ-017 In RUNx with en=1 and w==x, the FSM SHALL stay in RUNx and increment the count, saturating at RUN_LEN.
REQ-018 In RUNx with en=1 and w!=x, the FSM SHALL go to RUN<w> and set the count to 1; no IDLE gap.
REQ-019 When en=0, state and count SHALL hold.
REQ-020 When clr=1, the next state SHALL be IDLE with count 0, taking priority over en and w.
REQ-021 z SHALL be Moore, combinational from registered state and mode: z = (count==RUN_LEN) AND state-value permitted by mode.
REQ-022 Latency: z SHALL rise the cycle after the posedge that accepts the RUN_LEN-th matching symbol.
REQ-023 z SHALL stay high while further matching symbols arrive (overlapping detection) and fall the cycle after a mismatching symbol is accepted.
REQ-024 A mode change SHALL affect z in the same cycle and SHALL NOT alter state or count.
REQ-025 z_val SHALL be 1 in RUN1 and 0 otherwise; run_len SHALL equal the count; curr_state SHALL equal the state code.

Reset
REQ-026 nReset low SHALL immediately force IDLE, count 0, and hit_cnt 0 (if present), regardless of Clock.
REQ-027 During reset, z=0, z_val=0, run_len=0, curr_state=0.
REQ-028 Reset asserted mid-run SHALL discard the run; after release, counting SHALL restart from 1 on the next accepted symbol.
REQ-029 Reset release SHALL NOT itself count as a sample.

Configuration
REQ-030 With macro SEQ_RUN_HITCNT_EN defined, hit_cnt SHALL exist and increment by 1 on each edge where registered z goes from 0 to 1.
- hit_cnt saturates at 2**HIT_W-1.
- hit_cnt is cleared by clr and by nReset.
- Without the macro, the hit_cnt port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 mode=00, en=1, w=0,0,0,0,0 -> z=0 for the first 3 samples, z=1 after the 4th, z=1 after the 5th; run_len=4 saturated; z_val=0.
REQ-032 mode=10, w=1,1,1,1 -> run_len=4 and z_val=1 but z=0; switching to mode=00 drives z=1 in the same cycle.
REQ-033 w=1,1,1,0,1,1,1,1 with en=1 -> run_len goes 1,2,3,1,1,2,3,4; z=1 only after the final sample.
REQ-034 w=0,0,en=0 for 3 cycles, then w=0,0 -> run_len holds at 2 during en=0; z=1 after the 4th accepted zero.
REQ-035 During a run with run_len=3, assert clr (and separately nReset asynchronously between edges) -> IDLE, run_len=0, z=0; the next w=1 gives run_len=1.
REQ-036 With SEQ_RUN_HITCNT_EN, HIT_W=2: five separate 4-long runs -> hit_cnt reads 1,2,3,3,3; clr returns it to 0.
